hpi_responder: RTL and testbench

- Synthesizable responder for the CY7C67200 HPI bus: the chip end of the link that hpi_io_intf drives.
- Decodes the host's CS/RD/WR strobes and 2-bit address into four HPI registers: DATA, MAILBOX, ADDRESS and STATUS.
- Backs DATA with an internal 16-bit word RAM; a local port lets a keyboard or keycode emulator fill that RAM and exchange mailbox words with the host.
- Used in the loop-back test build and as the bench model for the NIOS HPI driver.

---
 rtl/hpi_pkg.sv | 27 ++
 rtl/hpi_dpram.sv | 52 +++++
 rtl/hpi_responder.sv | 201 ++++++++++++++++++++
 tb/tb_hpi_responder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpi_pkg.sv
// Shared types and constants for the CY7C67200 HPI responder.
// Covers register selects, FSM states, STATUS bit positions and host strobe timing.
package hpi_pkg;

  typedef enum logic [1:0] {
    HPI_DATA    = 2'd0,
    HPI_MAILBOX = 2'd1,
    HPI_ADDRESS = 2'd2,
    HPI_STATUS  = 2'd3
  } hpi_reg_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_COMMIT,
    ST_RD_FETCH1,
    ST_RD_FETCH2,
    ST_WAIT_RELEASE
  } hpi_state_e;

  localparam int STAT_MBX_IN_BIT  = 0;
  localparam int STAT_MBX_OUT_BIT = 1;

  // Host strobe timing, in Clk cycles
  localparam int STROBE_MIN_LOW  = 4;
  localparam int STROBE_MIN_HIGH = 2;

endpackage

// File: rtl/hpi_dpram.sv
// True dual-port 16-bit word RAM with a registered read on both ports.
// Port A is the host side; it wins when both ports write the same word.
module hpi_dpram #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] a_addr,
  input  logic          a_we,
  input  logic [15:0]   a_wdata,
  output logic [15:0]   a_rdata,
  input  logic [AW-1:0] b_addr,
  input  logic          b_we,
  input  logic [15:0]   b_wdata,
  output logic [15:0]   b_rdata
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [15:0] mem [DEPTH];
  logic [15:0] a_rdata_d, a_rdata_q;
  logic [15:0] b_rdata_d, b_rdata_q;
  logic        a_ok, b_ok;

  always_comb begin
    a_ok      = ({1'b0, a_addr} < DEPTH_W);
    b_ok      = ({1'b0, b_addr} < DEPTH_W);
    a_rdata_d = a_ok ? mem[a_addr] : 16'h0000;
    b_rdata_d = b_ok ? mem[b_addr] : 16'h0000;
  end

  // Port A is written last so it overrides a same-word port B write
  always_ff @(posedge clk) begin
    if (b_we && b_ok) mem[b_addr] <= b_wdata;
    if (a_we && a_ok) mem[a_addr] <= a_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata_q <= 16'h0000;
      b_rdata_q <= 16'h0000;
    end else begin
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: rtl/hpi_responder.sv
// Chip-side responder for the CY7C67200 HPI bus: DATA/MAILBOX/ADDRESS/STATUS
// registers, a RAM behind DATA, and a local port for filling RAM and mailboxes.
module hpi_responder
  import hpi_pkg::*;
#(
  parameter int MEM_DEPTH = 4096,
  parameter int MEM_AW    = 12
) (
  input  logic              Clk,
  input  logic              Reset_n,
  inout  wire  [15:0]       OTG_DATA,
  input  logic [1:0]        OTG_ADDR,
  input  logic              OTG_CS_N,
  input  logic              OTG_RD_N,
  input  logic              OTG_WR_N,
  input  logic              OTG_RST_N,
  output logic              OTG_INT,
  input  logic [MEM_AW-1:0] loc_addr,
  input  logic [15:0]       loc_wdata,
  input  logic              loc_we,
  output logic [15:0]       loc_rdata,
  output logic [15:0]       loc_mbx_in,
  output logic              loc_mbx_in_valid,
  input  logic              loc_mbx_ack,
  input  logic [15:0]       loc_mbx_out,
  input  logic              loc_mbx_post,
  output logic              protocol_err
);

  localparam logic [15:0] DEPTH_W = 16'(MEM_DEPTH);

  // ctrl bits: {RST_N, WR_N, RD_N, CS_N}
  logic [3:0]  ctrl_s1_d, ctrl_s1_q, ctrl_s2_d, ctrl_s2_q;
  logic [1:0]  addr_s1_d, addr_s1_q, addr_s2_d, addr_s2_q;
  logic [15:0] data_s1_d, data_s1_q, data_s2_d, data_s2_q;
  hpi_state_e  state_d, state_q;
  hpi_reg_e    acc_reg_d, acc_reg_q;
  logic [15:0] wdata_d, wdata_q;
  logic [15:0] hpi_addr_d, hpi_addr_q;
  logic [15:0] mbx_in_d, mbx_in_q;
  logic [15:0] mbx_out_d, mbx_out_q;
  logic [1:0]  status_d, status_q;
  logic [15:0] rd_reg_d, rd_reg_q;
  logic        perr_d, perr_q;

  logic        sync_cs, sync_rd, sync_wr, soft_rst, in_range, host_we, bus_oe;
  logic [15:0] host_rdata;

  hpi_dpram #(.DEPTH(MEM_DEPTH), .AW(MEM_AW)) u_ram (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .a_addr  (hpi_addr_q[MEM_AW:1]),
    .a_we    (host_we),
    .a_wdata (wdata_q),
    .a_rdata (host_rdata),
    .b_addr  (loc_addr),
    .b_we    (loc_we),
    .b_wdata (loc_wdata),
    .b_rdata (loc_rdata)
  );

  always_comb begin
    sync_cs  = ~ctrl_s2_q[0];
    sync_rd  = ~ctrl_s2_q[1];
    sync_wr  = ~ctrl_s2_q[2];
    soft_rst = ~ctrl_s2_q[3];
    in_range = ({1'b0, hpi_addr_q[15:1]} < DEPTH_W);
    host_we  = (state_q == ST_WR_COMMIT) && (acc_reg_q == HPI_DATA) && in_range && !soft_rst;

    ctrl_s1_d  = {OTG_RST_N, OTG_WR_N, OTG_RD_N, OTG_CS_N};
    ctrl_s2_d  = ctrl_s1_q;
    addr_s1_d  = OTG_ADDR;
    addr_s2_d  = addr_s1_q;
    data_s1_d  = OTG_DATA;
    data_s2_d  = data_s1_q;
    state_d    = state_q;
    acc_reg_d  = acc_reg_q;
    wdata_d    = wdata_q;
    hpi_addr_d = hpi_addr_q;
    mbx_in_d   = mbx_in_q;
    mbx_out_d  = mbx_out_q;
    status_d   = status_q;
    rd_reg_d   = rd_reg_q;
    perr_d     = perr_q;

    // A local ack is applied first so a host mailbox write in the same cycle overrides it
    if (loc_mbx_ack) status_d[STAT_MBX_IN_BIT] = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sync_cs && sync_rd && sync_wr) begin
          perr_d  = 1'b1;
          state_d = ST_WAIT_RELEASE;
        end else if (sync_cs && sync_wr) begin
          acc_reg_d = hpi_reg_e'(addr_s2_q);
          wdata_d   = data_s2_q;
          state_d   = ST_WR_COMMIT;
        end else if (sync_cs && sync_rd) begin
          acc_reg_d = hpi_reg_e'(addr_s2_q);
          state_d   = ST_RD_FETCH1;
        end
      end
      ST_WR_COMMIT: begin
        case (acc_reg_q)
          HPI_DATA:    hpi_addr_d = hpi_addr_q + 16'd2;
          HPI_MAILBOX: begin
            mbx_in_d                   = wdata_q;
            status_d[STAT_MBX_IN_BIT]  = 1'b1;
          end
          HPI_ADDRESS: hpi_addr_d = wdata_q;
          default: ;
        endcase
        state_d = ST_WAIT_RELEASE;
      end
      ST_RD_FETCH1: state_d = ST_RD_FETCH2;
      ST_RD_FETCH2: begin
        case (acc_reg_q)
          HPI_DATA: begin
            rd_reg_d   = in_range ? host_rdata : 16'h0000;
            hpi_addr_d = hpi_addr_q + 16'd2;
          end
          HPI_MAILBOX: begin
            rd_reg_d                   = mbx_out_q;
            status_d[STAT_MBX_OUT_BIT] = 1'b0;
          end
          HPI_ADDRESS: rd_reg_d = hpi_addr_q;
          default:     rd_reg_d = {14'b0, status_q};
        endcase
        state_d = ST_WAIT_RELEASE;
      end
      ST_WAIT_RELEASE: begin
        if (!sync_cs && !sync_rd && !sync_wr) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A post lands after the host read so it keeps the outbound flag set
    if (loc_mbx_post) begin
      if (status_q[STAT_MBX_OUT_BIT]) perr_d = 1'b1;
      mbx_out_d                   = loc_mbx_out;
      status_d[STAT_MBX_OUT_BIT]  = 1'b1;
    end

    if (soft_rst) begin
      state_d    = ST_IDLE;
      acc_reg_d  = HPI_DATA;
      wdata_d    = 16'h0000;
      hpi_addr_d = 16'h0000;
      mbx_in_d   = 16'h0000;
      mbx_out_d  = 16'h0000;
      status_d   = 2'b00;
      rd_reg_d   = 16'h0000;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ctrl_s1_q  <= 4'hF;
      ctrl_s2_q  <= 4'hF;
      addr_s1_q  <= 2'b00;
      addr_s2_q  <= 2'b00;
      data_s1_q  <= 16'h0000;
      data_s2_q  <= 16'h0000;
      state_q    <= ST_IDLE;
      acc_reg_q  <= HPI_DATA;
      wdata_q    <= 16'h0000;
      hpi_addr_q <= 16'h0000;
      mbx_in_q   <= 16'h0000;
      mbx_out_q  <= 16'h0000;
      status_q   <= 2'b00;
      rd_reg_q   <= 16'h0000;
      perr_q     <= 1'b0;
    end else begin
      ctrl_s1_q  <= ctrl_s1_d;
      ctrl_s2_q  <= ctrl_s2_d;
      addr_s1_q  <= addr_s1_d;
      addr_s2_q  <= addr_s2_d;
      data_s1_q  <= data_s1_d;
      data_s2_q  <= data_s2_d;
      state_q    <= state_d;
      acc_reg_q  <= acc_reg_d;
      wdata_q    <= wdata_d;
      hpi_addr_q <= hpi_addr_d;
      mbx_in_q   <= mbx_in_d;
      mbx_out_q  <= mbx_out_d;
      status_q   <= status_d;
      rd_reg_q   <= rd_reg_d;
      perr_q     <= perr_d;
    end
  end

  // Only a clean host read (CS and RD low, WR high) may drive the bus
  assign bus_oe   = Reset_n & ~soft_rst & ~OTG_CS_N & ~OTG_RD_N & OTG_WR_N;
  assign OTG_DATA = bus_oe ? rd_reg_q : 16'hzzzz;

  assign OTG_INT          = status_q[STAT_MBX_OUT_BIT];
  assign loc_mbx_in_valid = status_q[STAT_MBX_IN_BIT];
  assign loc_mbx_in       = mbx_in_q;
  assign protocol_err     = perr_q;

endmodule

// File: tb/tb_hpi_responder.sv
// Self-checking bench for hpi_responder: table-driven host accesses with a read
// scoreboard, plus hand-written mailbox, collision and reset sequences.
module tb_hpi_responder;
  import hpi_pkg::*;

  localparam int HOLD_CYC = 2 * STROBE_MIN_LOW;
  localparam int GAP_CYC  = 2 * STROBE_MIN_HIGH + 1;

  localparam int K_WR  = 0;
  localparam int K_RD  = 1;
  localparam int K_LOC = 2;

  localparam int P_NONE = 0;
  localparam int P_WE   = 1;
  localparam int P_POST = 2;
  localparam int P_ACK  = 3;

  logic        clk;
  logic        rst_n;
  wire  [15:0] otg_data;
  logic [15:0] host_data;
  logic        host_drive;
  logic [1:0]  otg_addr;
  logic        otg_cs_n, otg_rd_n, otg_wr_n, otg_rst_n, otg_int;
  logic [11:0] loc_addr;
  logic [15:0] loc_wdata, loc_rdata, loc_mbx_in, loc_mbx_out;
  logic        loc_we, loc_mbx_in_valid, loc_mbx_ack, loc_mbx_post, protocol_err;

  typedef struct {
    int          kind;
    logic [1:0]  regsel;
    logic [15:0] data;
    int          psel;
    int          pedge;
    logic [15:0] pval;
    logic [11:0] laddr;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  assign otg_data = host_drive ? host_data : 16'hzzzz;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  hpi_responder #(.MEM_DEPTH(4096), .MEM_AW(12)) dut (
    .Clk              (clk),
    .Reset_n          (rst_n),
    .OTG_DATA         (otg_data),
    .OTG_ADDR         (otg_addr),
    .OTG_CS_N         (otg_cs_n),
    .OTG_RD_N         (otg_rd_n),
    .OTG_WR_N         (otg_wr_n),
    .OTG_RST_N        (otg_rst_n),
    .OTG_INT          (otg_int),
    .loc_addr         (loc_addr),
    .loc_wdata        (loc_wdata),
    .loc_we           (loc_we),
    .loc_rdata        (loc_rdata),
    .loc_mbx_in       (loc_mbx_in),
    .loc_mbx_in_valid (loc_mbx_in_valid),
    .loc_mbx_ack      (loc_mbx_ack),
    .loc_mbx_out      (loc_mbx_out),
    .loc_mbx_post     (loc_mbx_post),
    .protocol_err     (protocol_err)
  );

  function automatic vec_t mk(int kind, logic [1:0] regsel, logic [15:0] data,
                              int psel, int pedge, logic [15:0] pval, logic [11:0] laddr);
    vec_t v;
    v.kind = kind; v.regsel = regsel; v.data = data;
    v.psel = psel; v.pedge = pedge; v.pval = pval; v.laddr = laddr;
    return v;
  endfunction

  task automatic checkOutput(string name, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkReleased(string name);
    n_checks++;
    if (!($isunknown(otg_data) || otg_data == 16'h0000)) begin
      n_fail++;
      $display("[TB] FAIL %s: bus driven with %h, expected released", name, otg_data);
    end
  endtask

  task automatic setLocal(int sel, logic [15:0] val, logic [11:0] la, logic on);
    case (sel)
      P_WE:   begin loc_addr = la; loc_wdata = val; loc_we = on; end
      P_POST: begin loc_mbx_out = val; loc_mbx_post = on; end
      P_ACK:  loc_mbx_ack = on;
      default: ;
    endcase
  endtask

  task automatic localPulse(int sel, logic [15:0] val, logic [11:0] la);
    @(negedge clk);
    setLocal(sel, val, la, 1'b1);
    @(negedge clk);
    setLocal(sel, val, la, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  // One host access; an optional local pulse spans the posedge after negedge 'pedge'
  task automatic applyStimulus(int kind, logic [1:0] regsel, logic [15:0] data, int psel,
                               int pedge, logic [15:0] pval, logic [11:0] la, string name);
    if (kind == K_LOC) begin
      localPulse(psel, pval, la);
      return;
    end
    @(negedge clk);
    otg_addr   = regsel;
    host_data  = data;
    host_drive = (kind == K_WR);
    otg_cs_n   = 1'b0;
    if (kind == K_RD) begin
      otg_rd_n = 1'b0;
      exp_q.push_back(data);
    end else begin
      otg_wr_n = 1'b0;
    end
    for (int i = 1; i <= HOLD_CYC; i++) begin
      @(negedge clk);
      if (psel != P_NONE && i == pedge) setLocal(psel, pval, la, 1'b1);
      else if (psel != P_NONE && i == pedge + 1) setLocal(psel, pval, la, 1'b0);
    end
    if (kind == K_RD) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: no expected value queued", name);
      end else begin
        checkOutput(name, otg_data, exp_q.pop_front());
      end
    end
    otg_cs_n   = 1'b1;
    otg_rd_n   = 1'b1;
    otg_wr_n   = 1'b1;
    host_drive = 1'b0;
    repeat (GAP_CYC) @(negedge clk);
  endtask

  task automatic runTable(string tag);
    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i].kind, vecs[i].regsel, vecs[i].data, vecs[i].psel,
                    vecs[i].pedge, vecs[i].pval, vecs[i].laddr, $sformatf("%s_%0d", tag, i));
    vecs.delete();
  endtask

  task automatic hostWrite(logic [1:0] r, logic [15:0] d, string name);
    applyStimulus(K_WR, r, d, P_NONE, 0, 16'h0, 12'h0, name);
  endtask

  task automatic hostRead(logic [1:0] r, logic [15:0] e, string name);
    applyStimulus(K_RD, r, e, P_NONE, 0, 16'h0, 12'h0, name);
  endtask

  task automatic checkLocal(logic [11:0] la, logic [15:0] e, string name);
    @(negedge clk);
    loc_addr = la;
    repeat (2) @(negedge clk);
    checkOutput(name, loc_rdata, e);
  endtask

  initial begin
    rst_n = 1'b0; otg_rst_n = 1'b1; host_drive = 1'b0; host_data = 16'h0;
    otg_addr = 2'd0; otg_cs_n = 1'b1; otg_rd_n = 1'b1; otg_wr_n = 1'b1;
    loc_addr = 12'h0; loc_wdata = 16'h0; loc_we = 1'b0;
    loc_mbx_ack = 1'b0; loc_mbx_out = 16'h0; loc_mbx_post = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_int", {15'b0, otg_int}, 16'h0);
    checkOutput("rst_perr", {15'b0, protocol_err}, 16'h0);
    checkOutput("rst_mbx_in", loc_mbx_in, 16'h0);
    checkReleased("rst_bus");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Sequential DATA writes/reads, high-address drop and wrap, local/host RAM sharing
    vecs.push_back(mk(K_WR,  HPI_ADDRESS, 16'h0010, P_NONE, 0, 16'h0,    12'h0));
    vecs.push_back(mk(K_WR,  HPI_DATA,    16'hAAAA, P_NONE, 0, 16'h0,    12'h0));
    vecs.push_back(mk(K_WR,  HPI_DATA,    16'h5555, P_NONE, 0, 16'h0,    12'h0));
    vecs.push_back(mk(K_WR,  HPI_ADDRESS, 16'h0010, P_NONE, 0, 16'h0,    12'h0));
    vecs.push_back(mk(K_RD,  HPI_DATA,    16'hAAAA, P_NONE, 0, 16'h0,    12'h0));
    vecs.push_back(mk(K_RD,  HPI_DATA,    16'h5555, P_NONE, 0, 16'h0,    12'h0));
    vecs.push_back(mk(K_RD,  HPI_ADDRESS, 16'h0014, P_NONE, 0, 16'h0,    12'h0));
    vecs.push_back(mk(K_LOC, HPI_DATA,    16'h0000, P_WE,   0, 16'h0000, 12'hFFF));
    vecs.push_back(mk(K_WR,  HPI_ADDRESS, 16'hFFFE, P_NONE, 0, 16'h0,    12'h0));
    vecs.push_back(mk(K_WR,  HPI_DATA,    16'h1234, P_NONE, 0, 16'h0,    12'h0));
    vecs.push_back(mk(K_RD,  HPI_ADDRESS, 16'h0000, P_NONE, 0, 16'h0,    12'h0));
    vecs.push_back(mk(K_LOC, HPI_DATA,    16'h0000, P_WE,   0, 16'h001A, 12'h003));
    vecs.push_back(mk(K_WR,  HPI_ADDRESS, 16'h0006, P_NONE, 0, 16'h0,    12'h0));
    vecs.push_back(mk(K_RD,  HPI_DATA,    16'h001A, P_NONE, 0, 16'h0,    12'h0));
    vecs.push_back(mk(K_WR,  HPI_ADDRESS, 16'h0008, P_NONE, 0, 16'h0,    12'h0));
    vecs.push_back(mk(K_WR,  HPI_DATA,    16'hBEEF, P_WE,   3, 16'hDEAD, 12'h004));
    vecs.push_back(mk(K_RD,  HPI_ADDRESS, 16'h000A, P_NONE, 0, 16'h0,    12'h0));
    runTable("data");
    checkLocal(12'hFFF, 16'h0000, "oob_write_dropped");
    checkLocal(12'h004, 16'hBEEF, "host_wins_same_word");
    checkLocal(12'h008, 16'hAAAA, "loc_read_word8");

    // Inbound mailbox and ack
    hostWrite(HPI_MAILBOX, 16'h0F00, "mbx_wr");
    checkOutput("mbx_in", loc_mbx_in, 16'h0F00);
    checkOutput("mbx_in_valid", {15'b0, loc_mbx_in_valid}, 16'h1);
    hostRead(HPI_STATUS, 16'h0001, "status_in");
    localPulse(P_ACK, 16'h0, 12'h0);
    hostRead(HPI_STATUS, 16'h0000, "status_acked");

    // Outbound mailbox, then a double post
    localPulse(P_POST, 16'hCAFE, 12'h0);
    checkOutput("int_after_post", {15'b0, otg_int}, 16'h1);
    hostRead(HPI_STATUS, 16'h0002, "status_out");
    hostRead(HPI_MAILBOX, 16'hCAFE, "mbx_rd");
    checkOutput("int_after_read", {15'b0, otg_int}, 16'h0);
    checkOutput("perr_clean", {15'b0, protocol_err}, 16'h0);
    localPulse(P_POST, 16'hAAAA, 12'h0);
    localPulse(P_POST, 16'hBBBB, 12'h0);
    checkOutput("perr_double_post", {15'b0, protocol_err}, 16'h1);
    hostRead(HPI_MAILBOX, 16'hBBBB, "mbx_overwritten");

    // Post landing in the same cycle as a mailbox read capture
    localPulse(P_POST, 16'h1111, 12'h0);
    applyStimulus(K_RD, HPI_MAILBOX, 16'h1111, P_POST, 4, 16'h2222, 12'h0, "mbx_rd_collide");
    checkOutput("int_post_wins", {15'b0, otg_int}, 16'h1);
    hostRead(HPI_MAILBOX, 16'h2222, "mbx_after_collide");

    // Ack landing in the same cycle as a host mailbox write
    applyStimulus(K_WR, HPI_MAILBOX, 16'h0F01, P_ACK, 3, 16'h0, 12'h0, "mbx_wr_collide");
    checkOutput("valid_write_wins", {15'b0, loc_mbx_in_valid}, 16'h1);

    // Asynchronous reset with every output non-zero
    localPulse(P_POST, 16'h3333, 12'h0);
    checkLocal(12'h004, 16'hBEEF, "loc_pre_reset");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #2;
    checkOutput("arst_int", {15'b0, otg_int}, 16'h0);
    checkOutput("arst_perr", {15'b0, protocol_err}, 16'h0);
    checkOutput("arst_valid", {15'b0, loc_mbx_in_valid}, 16'h0);
    checkOutput("arst_mbx_in", loc_mbx_in, 16'h0);
    checkOutput("arst_rdata", loc_rdata, 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // RD and WR asserted together
    hostWrite(HPI_ADDRESS, 16'h0030, "addr_set");
    hostRead(HPI_ADDRESS, 16'h0030, "addr_rd");
    @(negedge clk);
    otg_addr = HPI_ADDRESS; otg_cs_n = 1'b0; otg_rd_n = 1'b0; otg_wr_n = 1'b0;
    repeat (HOLD_CYC) @(negedge clk);
    checkReleased("rdwr_bus");
    otg_cs_n = 1'b1; otg_rd_n = 1'b1; otg_wr_n = 1'b1;
    repeat (GAP_CYC) @(negedge clk);
    checkOutput("rdwr_perr", {15'b0, protocol_err}, 16'h1);
    hostRead(HPI_ADDRESS, 16'h0030, "rdwr_no_change");

    // Host soft reset in the middle of a read
    hostWrite(HPI_ADDRESS, 16'h0010, "pre_soft_addr");
    hostWrite(HPI_MAILBOX, 16'h0777, "pre_soft_mbx");
    localPulse(P_POST, 16'h4444, 12'h0);
    @(negedge clk);
    otg_addr = HPI_DATA; otg_cs_n = 1'b0; otg_rd_n = 1'b0;
    repeat (3) @(negedge clk);
    otg_rst_n = 1'b0;
    repeat (5) @(negedge clk);
    checkReleased("soft_bus");
    checkOutput("soft_int", {15'b0, otg_int}, 16'h0);
    otg_cs_n = 1'b1; otg_rd_n = 1'b1;
    repeat (4) @(negedge clk);
    otg_rst_n = 1'b1;
    repeat (GAP_CYC) @(negedge clk);
    checkOutput("soft_valid", {15'b0, loc_mbx_in_valid}, 16'h0);
    checkOutput("soft_mbx_in", loc_mbx_in, 16'h0);
    checkOutput("soft_perr_kept", {15'b0, protocol_err}, 16'h1);
    hostRead(HPI_ADDRESS, 16'h0000, "soft_addr");
    hostRead(HPI_MAILBOX, 16'h0000, "soft_mbx_out");
    hostWrite(HPI_ADDRESS, 16'h0010, "post_soft_addr");
    hostRead(HPI_DATA, 16'hAAAA, "soft_ram_kept");

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
